rmt_ingress_guard: RTL and testbench
====================================

Name: rmt_ingress_guard

Overview:
- Sits directly upstream of the RMT pipeline wrapper and feeds its s_axis slave port.
- Receives MAC-side AXI-Stream with no backpressure and buffers it in a beat FIFO.
- Admits or drops each packet whole, so the parser and packet FIFO downstream never see a partial packet.
- Truncates oversize packets to a fixed beat limit and keeps drop and truncate statistics.

Parameters:
- C_S_AXIS_DATA_WIDTH, 256, tdata width in bits; tkeep is C_S_AXIS_DATA_WIDTH/8.
- C_S_AXIS_TUSER_WIDTH, 128, tuser width in bits.
- DEPTH_BITS, 6, FIFO depth = 2**DEPTH_BITS beats (64).
- MAX_PKT_BEATS, 48, maximum admitted packet length in beats; must be <= 2**DEPTH_BITS.

Ports:
- clk  in  1  single clock for the whole block.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  C_S_AXIS_DATA_WIDTH  ingress data.
- s_axis_tkeep  in  C_S_AXIS_DATA_WIDTH/8  ingress byte enables.
- s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  ingress sideband.
- s_axis_tvalid  in  1  ingress beat valid.
- s_axis_tready  out  1  0 while aresetn=0, otherwise 1; the source is never stalled.
- s_axis_tlast  in  1  ingress end of packet.
- m_axis_tdata  out  C_S_AXIS_DATA_WIDTH  data to the pipeline wrapper.
- m_axis_tkeep  out  C_S_AXIS_DATA_WIDTH/8  byte enables to the wrapper.
- m_axis_tuser  out  C_S_AXIS_TUSER_WIDTH  sideband to the wrapper.
- m_axis_tvalid  out  1  FIFO non-empty.
- m_axis_tready  in  1  wrapper accepts the head beat.
- m_axis_tlast  out  1  end of packet toward the wrapper.
- drop_cnt  out  32  packets dropped whole.
- trunc_cnt  out  32  packets truncated.

Behaviour:
- Reset is asynchronous; all state clears immediately on aresetn=0.
  - FIFO empty, occupancy 0, state IDLE.
  - m_axis_tvalid=0, drop_cnt=0, trunc_cnt=0.
  - m_axis data outputs are don't-care while m_axis_tvalid=0.
- FIFO occupancy:
  - count increments on a write, decrements on a read (m_axis_tvalid & m_axis_tready), and is unchanged when both happen in the same cycle.
  - free = 2**DEPTH_BITS - count, taken from the registered count before this cycle's read, which makes admission conservative.
  - Write and read pointers are DEPTH_BITS wide and wrap naturally.
- State machine; a beat is any cycle with s_axis_tvalid=1.
  - IDLE: the beat is start of packet (SOP).
    - If free >= MAX_PKT_BEATS: write the beat, beat_cnt=1; go to PASS unless tlast.
    - Otherwise: drop the beat, drop_cnt+1; go to DROP unless tlast.
  - PASS: write each beat, beat_cnt+1.
    - tlast: return to IDLE.
    - beat_cnt reaches MAX_PKT_BEATS without tlast: write that beat with tlast forced to 1, trunc_cnt+1, go to DROP.
  - DROP: discard beats; return to IDLE on tlast.
- Admission guarantees the FIFO never overflows.
- The first beat after reset deassertion is always treated as SOP.
- Latency: a beat written in cycle N is presented on m_axis in cycle N+1 if the FIFO was empty (registered first-word fall-through).
- m_axis contents stay stable while m_axis_tvalid=1 and m_axis_tready=0.
- Counters saturate at 0xFFFFFFFF.
- Single-beat packet (tlast on the SOP beat): admitted or dropped, and the state stays IDLE.

Optional Feature:
- Macro: RMT_INGRESS_GUARD_STATS_EN.
- Defined: drop_cnt and trunc_cnt are implemented as described.
- Undefined:
  - No counter registers are built; drop_cnt and trunc_cnt are tied to 0.
  - Admission, truncation and the datapath are unchanged.

Test Plan:
- 3-beat packet, m_axis_tready=1: identical 3 beats out, first at N+1, tlast on beat 3, drop_cnt=0.
- m_axis_tready=0, 48-beat packet then 10-beat packet (free=16<48): only the 48 beats are buffered. After tready=1, exactly 48 beats are output, and drop_cnt=1.
- count=16 (free=48) with simultaneous read on the SOP cycle: packet admitted (free==MAX_PKT_BEATS), drop_cnt unchanged.
- 50-beat packet: 48 beats out, beat 48 tlast=1, beats 49-50 discarded, trunc_cnt=1. A following 2-beat packet passes intact.
- 1-beat packets back-to-back every cycle with tready=1: all pass at 1 beat/cycle, state stays IDLE, counters 0.
- aresetn low mid-packet with FIFO holding 20 beats: m_axis_tvalid=0 within the same cycle, counters 0. After release, the next beat is treated as SOP.

Source files
------------

// File: rtl/rmt_ingress_guard.sv
// Ingress guard ahead of the RMT pipeline: buffers MAC beats, admits or drops whole packets, truncates oversize ones.
// Optional statistics counters are built only when RMT_INGRESS_GUARD_STATS_EN is defined.
module rmt_ingress_guard #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int DEPTH_BITS           = 6,
  parameter int MAX_PKT_BEATS        = 48
) (
  input  logic                              clk,
  input  logic                              aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic [31:0]                       drop_cnt,
  output logic [31:0]                       trunc_cnt
);
  localparam int KEEP_W  = C_S_AXIS_DATA_WIDTH / 8;
  localparam int ENTRY_W = C_S_AXIS_DATA_WIDTH + KEEP_W + C_S_AXIS_TUSER_WIDTH + 1;
  localparam int DEPTH   = 2 ** DEPTH_BITS;
  localparam int BCNT_W  = $clog2(MAX_PKT_BEATS + 1);

  localparam logic [DEPTH_BITS:0] L_DEPTH     = {1'b1, {DEPTH_BITS{1'b0}}};
  localparam logic [DEPTH_BITS:0] L_MAX_FREE  = MAX_PKT_BEATS[DEPTH_BITS:0];
  localparam logic [BCNT_W-1:0]   L_MAX_BEATS = MAX_PKT_BEATS[BCNT_W-1:0];

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PASS = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [ENTRY_W-1:0]    r_mem [DEPTH];
  logic [DEPTH_BITS-1:0] r_wr_ptr;
  logic [DEPTH_BITS-1:0] r_rd_ptr;
  logic [DEPTH_BITS:0]   r_count;
  logic [1:0]            r_state;
  logic [BCNT_W-1:0]     r_beat_cnt;

  logic [DEPTH_BITS:0]   w_free;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_force_last;
  logic                  w_drop_pkt;
  logic                  w_trunc_pkt;
  logic [1:0]            w_state_nxt;
  logic [BCNT_W-1:0]     w_beat_nxt;
  logic [ENTRY_W-1:0]    w_wr_entry;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Free space uses the pre-read occupancy, so admission never counts on a same-cycle read.
  assign w_free        = L_DEPTH - r_count;
  assign w_rd          = m_axis_tvalid & m_axis_tready;
  assign w_wr_entry    = {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast | w_force_last};
  assign s_axis_tready = aresetn;

  always_comb begin
    w_state_nxt  = r_state;
    w_beat_nxt   = r_beat_cnt;
    w_wr         = 1'b0;
    w_force_last = 1'b0;
    w_drop_pkt   = 1'b0;
    w_trunc_pkt  = 1'b0;
    if (s_axis_tvalid) begin
      case (r_state)
        S_IDLE: begin
          if (w_free >= L_MAX_FREE) begin
            w_wr       = 1'b1;
            w_beat_nxt = BCNT_W'(1);
            if (!s_axis_tlast) w_state_nxt = S_PASS;
          end else begin
            w_drop_pkt = 1'b1;
            if (!s_axis_tlast) w_state_nxt = S_DROP;
          end
        end
        S_PASS: begin
          w_wr       = 1'b1;
          w_beat_nxt = r_beat_cnt + BCNT_W'(1);
          if (s_axis_tlast) begin
            w_state_nxt = S_IDLE;
          end else if (w_beat_nxt == L_MAX_BEATS) begin
            w_force_last = 1'b1;
            w_trunc_pkt  = 1'b1;
            w_state_nxt  = S_DROP;
          end
        end
        S_DROP: begin
          if (s_axis_tlast) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= S_IDLE;
      r_beat_cnt <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_nxt;
      if (w_wr) r_wr_ptr <= r_wr_ptr + DEPTH_BITS'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + DEPTH_BITS'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (DEPTH_BITS+1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_BITS+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_wr_entry;
  end

  // Head entry is read straight from the register array: first-word fall-through one cycle after the write.
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = r_mem[r_rd_ptr];
  assign m_axis_tvalid = (r_count != '0);

`ifdef RMT_INGRESS_GUARD_STATS_EN
  logic [31:0] r_drop_cnt;
  logic [31:0] r_trunc_cnt;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_drop_cnt  <= '0;
      r_trunc_cnt <= '0;
    end else begin
      if (w_drop_pkt)  r_drop_cnt  <= sat_inc(r_drop_cnt);
      if (w_trunc_pkt) r_trunc_cnt <= sat_inc(r_trunc_cnt);
    end
  end

  assign drop_cnt  = r_drop_cnt;
  assign trunc_cnt = r_trunc_cnt;
`else
  logic [32:0] w_unused_stats;
  assign w_unused_stats = {w_drop_pkt ^ w_trunc_pkt, sat_inc(32'd0)};
  assign drop_cnt       = 32'd0;
  assign trunc_cnt      = 32'd0;
`endif

endmodule

// File: tb/tb_rmt_ingress_guard.sv
// Self-checking bench for rmt_ingress_guard against a packet-level queue model.
module tb_rmt_ingress_guard;
  localparam int DW = 256, KW = 32, UW = 128, DEPTH = 64, MAXB = 48;
  localparam int EW = DW + KW + UW + 1;

  logic          clk = 1'b0;
  logic          aresetn;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic [UW-1:0] s_tuser;
  logic          s_tvalid, s_tlast, s_tready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic [UW-1:0] m_tuser;
  logic          m_tvalid, m_tready, m_tlast;
  logic [31:0]   drop_cnt, trunc_cnt;

  int checks = 0;
  int errors = 0;

  rmt_ingress_guard #(
    .C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW), .DEPTH_BITS(6), .MAX_PKT_BEATS(MAXB)
  ) dut (
    .clk(clk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .drop_cnt(drop_cnt), .trunc_cnt(trunc_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: queue of buffered beats plus packet mode (0 idle, 1 passing, 2 dropping).
  logic [EW-1:0] mq[$];
  int            m_mode = 0;
  int            m_len = 0;
  int            mfree;
  logic [EW-1:0] mb;
  logic [31:0]   m_drop = 0;
  logic [31:0]   m_trunc = 0;

  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      mq.delete();
      m_mode = 0; m_len = 0; m_drop = 0; m_trunc = 0;
    end else begin
      mfree = DEPTH - mq.size();
      if (mq.size() != 0 && m_tready) void'(mq.pop_front());
      if (s_tvalid) begin
        mb = {s_tdata, s_tkeep, s_tuser, s_tlast};
        if (m_mode == 0) begin
          if (mfree >= MAXB) begin
            mq.push_back(mb); m_len = 1;
            if (!s_tlast) m_mode = 1;
          end else begin
            if (m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 1;
            if (!s_tlast) m_mode = 2;
          end
        end else if (m_mode == 1) begin
          m_len = m_len + 1;
          if (s_tlast) m_mode = 0;
          else if (m_len == MAXB) begin
            mb[0] = 1'b1;
            if (m_trunc != 32'hFFFF_FFFF) m_trunc = m_trunc + 1;
            m_mode = 2;
          end
          mq.push_back(mb);
        end else if (s_tlast) begin
          m_mode = 0;
        end
      end
    end
  end

  logic [EW:0] dut_out;
  assign dut_out = m_tvalid ? {1'b1, m_tdata, m_tkeep, m_tuser, m_tlast} : '0;

  function automatic logic [EW:0] exp_out();
    return (mq.size() == 0) ? '0 : {1'b1, mq[0]};
  endfunction

  function automatic logic [31:0] exp_drop();
`ifdef RMT_INGRESS_GUARD_STATS_EN
    return m_drop;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_trunc();
`ifdef RMT_INGRESS_GUARD_STATS_EN
    return m_trunc;
`else
    return 32'd0;
`endif
  endfunction

  task automatic drive(input bit v, input bit l);
    s_tvalid = v;
    s_tlast  = l;
    s_tdata  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    s_tkeep  = $urandom();
    s_tuser  = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic settle();
    m_tready = 1'b1;
    drive(0, 0);
    repeat (70) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0; m_tready = 1'b0; drive(0, 0);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", m_tvalid); end
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %b want 0", s_tready); end
    checks++; if ({drop_cnt, trunc_cnt} !== 64'd0) begin errors++; $display("FAIL reset_counters got %h want 0", {drop_cnt, trunc_cnt}); end
    @(negedge clk); aresetn = 1'b1;
    @(posedge clk); #1;
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL release_tready got %b want 1", s_tready); end
  endtask

  task automatic test_three_beat();
    logic [DW-1:0] first;
    int n_out = 0, n_last = 0;
    bit last_on_third = 0;
    m_tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i < 3) drive(1, i == 2); else drive(0, 0);
      if (i == 0) first = s_tdata;
      if (m_tvalid && m_tready) begin
        n_out++;
        if (m_tlast) begin n_last++; last_on_third = (n_out == 3); end
      end
      @(posedge clk); #1;
      checks++; if (dut_out !== exp_out()) begin errors++; $display("FAIL three_beat cyc %0d got %h want %h", i, dut_out, exp_out()); end
      if (i == 0) begin
        checks++; if (m_tvalid !== 1'b1 || m_tdata !== first) begin errors++; $display("FAIL three_beat_latency got v=%b d=%h want v=1 d=%h", m_tvalid, m_tdata, first); end
      end
    end
    checks++; if (n_out != 3 || n_last != 1 || !last_on_third) begin errors++; $display("FAIL three_beat_count got beats=%0d lasts=%0d want 3/1 with last on beat 3", n_out, n_last); end
    checks++; if (drop_cnt !== 32'd0) begin errors++; $display("FAIL three_beat_drop got %0d want 0", drop_cnt); end
  endtask

  task automatic test_overflow_drop();
    int n_out = 0;
    settle();
    m_tready = 1'b0;
    for (int i = 0; i < 58; i++) begin
      drive(1, (i == 47) || (i == 57));
      @(posedge clk); #1;
      checks++; if (dut_out !== exp_out()) begin errors++; $display("FAIL overflow_fill cyc %0d got %h want %h", i, dut_out, exp_out()); end
    end
    checks++; if (drop_cnt !== exp_drop()) begin errors++; $display("FAIL overflow_drop_cnt got %0d want %0d", drop_cnt, exp_drop()); end
    m_tready = 1'b1; drive(0, 0);
    for (int i = 0; i < 60; i++) begin
      if (m_tvalid && m_tready) n_out++;
      @(posedge clk); #1;
      checks++; if (dut_out !== exp_out()) begin errors++; $display("FAIL overflow_drain cyc %0d got %h want %h", i, dut_out, exp_out()); end
    end
    checks++; if (n_out != 48) begin errors++; $display("FAIL overflow_beats_out got %0d want 48", n_out); end
  endtask

  task automatic test_free_boundary();
    int n_out = 0;
    settle();
    m_tready = 1'b0;
    for (int i = 0; i < 16; i++) begin drive(1, i == 15); @(posedge clk); #1; end
    m_tready = 1'b1;
    for (int i = 0; i < 110; i++) begin
      if (i < 48) drive(1, i == 47); else drive(0, 0);
      if (m_tvalid && m_tready) n_out++;
      @(posedge clk); #1;
      checks++; if (dut_out !== exp_out()) begin errors++; $display("FAIL free_eq cyc %0d got %h want %h", i, dut_out, exp_out()); end
    end
    checks++; if (n_out != 64) begin errors++; $display("FAIL free_eq_admit got %0d beats want 64", n_out); end
    checks++; if (drop_cnt !== exp_drop()) begin errors++; $display("FAIL free_eq_drop got %0d want %0d", drop_cnt, exp_drop()); end
    n_out = 0;
    m_tready = 1'b0;
    for (int i = 0; i < 65; i++) begin
      drive(1, (i == 16) || (i == 64));
      @(posedge clk); #1;
    end
    m_tready = 1'b1; drive(0, 0);
    for (int i = 0; i < 40; i++) begin
      if (m_tvalid && m_tready) n_out++;
      @(posedge clk); #1;
      checks++; if (dut_out !== exp_out()) begin errors++; $display("FAIL free_lt cyc %0d got %h want %h", i, dut_out, exp_out()); end
    end
    checks++; if (n_out != 17) begin errors++; $display("FAIL free_lt_drop got %0d beats want 17", n_out); end
  endtask

  task automatic test_truncate();
    int n_out = 0, n_last = 0, last_pos = 0;
    logic [31:0] t0;
    settle();
    t0 = exp_trunc();
    for (int i = 0; i < 58; i++) begin
      if (i < 50) drive(1, i == 49);
      else if (i < 52) drive(1, i == 51);
      else drive(0, 0);
      if (m_tvalid && m_tready) begin
        n_out++;
        if (m_tlast) begin n_last++; if (n_last == 1) last_pos = n_out; end
      end
      @(posedge clk); #1;
      checks++; if (dut_out !== exp_out()) begin errors++; $display("FAIL truncate cyc %0d got %h want %h", i, dut_out, exp_out()); end
    end
    checks++; if (n_out != 50 || n_last != 2 || last_pos != 48) begin errors++; $display("FAIL truncate_shape got beats=%0d lasts=%0d first_last=%0d want 50/2/48", n_out, n_last, last_pos); end
    checks++; if (trunc_cnt !== exp_trunc()) begin errors++; $display("FAIL truncate_cnt got %0d want %0d", trunc_cnt, exp_trunc()); end
`ifdef RMT_INGRESS_GUARD_STATS_EN
    checks++; if (trunc_cnt !== t0 + 32'd1) begin errors++; $display("FAIL truncate_incr got %0d want %0d", trunc_cnt, t0 + 32'd1); end
`endif
  endtask

  task automatic test_back_to_back();
    int n_out = 0;
    settle();
    for (int i = 0; i < 24; i++) begin
      if (i < 20) drive(1, 1); else drive(0, 0);
      if (m_tvalid && m_tready) n_out++;
      @(posedge clk); #1;
      checks++; if (dut_out !== exp_out()) begin errors++; $display("FAIL back_to_back cyc %0d got %h want %h", i, dut_out, exp_out()); end
      if (i >= 0 && i < 20) begin
        checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL back_to_back_rate cyc %0d got tvalid=%b want 1", i, m_tvalid); end
      end
    end
    checks++; if (n_out != 20) begin errors++; $display("FAIL back_to_back_count got %0d want 20", n_out); end
    checks++; if ({drop_cnt, trunc_cnt} !== {exp_drop(), exp_trunc()}) begin errors++; $display("FAIL back_to_back_cnt got %h want %h", {drop_cnt, trunc_cnt}, {exp_drop(), exp_trunc()}); end
  endtask

  task automatic test_random();
    int rem = 0;
    for (int cyc = 0; cyc < 1000 && (cyc < 600 || rem != 0); cyc++) begin
      m_tready = ($urandom_range(9) < 7);
      if ($urandom_range(9) < 8) begin
        if (rem == 0) rem = $urandom_range(60, 1);
        drive(1, rem == 1);
        rem--;
      end else begin
        drive(0, 0);
      end
      @(posedge clk); #1;
      checks++; if (dut_out !== exp_out()) begin errors++; $display("FAIL random cyc %0d got %h want %h", cyc, dut_out, exp_out()); end
    end
    checks++; if ({drop_cnt, trunc_cnt} !== {exp_drop(), exp_trunc()}) begin errors++; $display("FAIL random_cnt got %h want %h", {drop_cnt, trunc_cnt}, {exp_drop(), exp_trunc()}); end
  endtask

  task automatic test_reset_midpacket();
    int n_out = 0, n_last = 0;
    settle();
    m_tready = 1'b0;
    for (int i = 0; i < 20; i++) begin drive(1, 0); @(posedge clk); #1; end
    drive(0, 0);
    #2 aresetn = 1'b0;
    #1;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL midreset_tvalid got %b want 0", m_tvalid); end
    checks++; if ({drop_cnt, trunc_cnt} !== 64'd0) begin errors++; $display("FAIL midreset_counters got %h want 0", {drop_cnt, trunc_cnt}); end
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL midreset_tready got %b want 0", s_tready); end
    @(posedge clk); @(negedge clk); aresetn = 1'b1;
    @(posedge clk); #1;
    m_tready = 1'b1;
    for (int i = 0; i < 46; i++) begin
      if (i < 40) drive(1, i == 39); else drive(0, 0);
      if (m_tvalid && m_tready) begin n_out++; if (m_tlast) n_last++; end
      @(posedge clk); #1;
      checks++; if (dut_out !== exp_out()) begin errors++; $display("FAIL post_reset cyc %0d got %h want %h", i, dut_out, exp_out()); end
    end
    checks++; if (n_out != 40 || n_last != 1) begin errors++; $display("FAIL post_reset_sop got beats=%0d lasts=%0d want 40/1", n_out, n_last); end
    checks++; if (trunc_cnt !== 32'd0) begin errors++; $display("FAIL post_reset_trunc got %0d want 0", trunc_cnt); end
  endtask

  initial begin
    test_reset();
    test_three_beat();
    test_overflow_drop();
    test_free_boundary();
    test_truncate();
    test_back_to_back();
    test_random();
    test_reset_midpacket();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout got no finish want finish before 1ms");
    $fatal(1);
  end
endmodule
